// File: rtl/reload_timer_pkg.sv
// -----------------------------------------------------------------------------
// reload_timer_pkg
// Shared definitions for the reload down-timer:
//   - state_e      : FSM state type (IDLE, RUN, HOLD)
//   - DEF_WIDTH    : default counter / reload-value width
//   - DEF_PRESCALE : default clock cycles per tick when the prescaler is built
// Optional feature macro used by this codebase: RELOAD_TIMER_PRESCALE_EN
// -----------------------------------------------------------------------------
package reload_timer_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_PRESCALE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage : reload_timer_pkg

// File: rtl/reload_timer_prescaler.sv
// -----------------------------------------------------------------------------
// reload_timer_prescaler
// Tick generator: while i_en is high, o_tick is asserted once every PRESCALE
// cycles. The count holds while i_en is low and returns to zero on i_clr.
// Only instantiated when RELOAD_TIMER_PRESCALE_EN is defined.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset, clears the count
//   i_en    - advance the count this cycle
//   i_clr   - synchronous clear (takes precedence over i_en)
//   o_tick  - high on the last cycle of each PRESCALE-cycle window while enabled
// -----------------------------------------------------------------------------
module reload_timer_prescaler
  import reload_timer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  // A one-bit counter is kept even for PRESCALE==1 so widths stay legal.
  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  // Prescale counter: wraps at LAST while enabled, holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : (r_cnt + CW'(1));
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tick = i_en & w_last;

endmodule : reload_timer_prescaler

// File: rtl/reload_down_timer.sv
// -----------------------------------------------------------------------------
// reload_down_timer
// Loadable down-counter with one-shot / auto-reload modes and pause support.
// FSM: IDLE -> RUN on start_i; RUN -> HOLD on stop_i; HOLD -> RUN on start_i;
// RUN -> IDLE at terminal count in one-shot mode.
// Optional macro: RELOAD_TIMER_PRESCALE_EN - when defined, ticks come from a
// prescaler (one every PRESCALE cycles in RUN); otherwise every cycle ticks.
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-high reset
//   load_i    - capture `load` into the reload register (any state)
//   load      - reload value
//   start_i   - start from IDLE / resume from HOLD
//   stop_i    - pause while in RUN (wins over start_i)
//   auto_i    - 1: auto-reload at terminal count, 0: one-shot
//   count_out - current down-count value
//   tc_o      - registered one-cycle terminal-count pulse
//   busy_o    - high in RUN or HOLD
// -----------------------------------------------------------------------------
module reload_down_timer
  import reload_timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             auto_i,
  output logic [WIDTH-1:0] count_out,
  output logic             tc_o,
  output logic             busy_o
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             r_tc;
  logic             w_tc_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             w_tick;

  if (PRESCALE < 1) begin : g_prescale_check
    $error("reload_down_timer: PRESCALE must be >= 1");
  end

`ifdef RELOAD_TIMER_PRESCALE_EN
  logic w_presc_en;
  logic w_presc_clr;

  // The stop edge must not advance the prescaler, so it only runs in RUN
  // without a pending stop; it restarts from zero on every fresh start.
  assign w_presc_en  = (r_state == RUN) & ~stop_i;
  assign w_presc_clr = (r_state == IDLE) & start_i;

  reload_timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_presc_en),
    .i_clr  (w_presc_clr),
    .o_tick (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_tc_nxt     = 1'b0;
    // The reload register follows load_i in every state.
    if (load_i) begin
      w_reload_nxt = load;
    end else begin
      w_reload_nxt = r_reload;
    end

    case (r_state)
      IDLE: begin
        // w_reload_nxt already carries `load` when load_i coincides with start.
        if (start_i) begin
          w_state_nxt = RUN;
          w_count_nxt = w_reload_nxt;
        end else if (load_i) begin
          w_count_nxt = load;
        end else begin
          w_count_nxt = r_count;
        end
      end
      RUN: begin
        if (stop_i) begin
          w_state_nxt = HOLD;
        end else if (w_tick) begin
          if (r_count == '0) begin
            w_tc_nxt = 1'b1;
            // Old reload value: a load on this edge applies from the next reload.
            if (auto_i) begin
              w_count_nxt = r_reload;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_count_nxt = r_count - WIDTH'(1);
          end
        end else begin
          w_count_nxt = r_count;
        end
      end
      HOLD: begin
        if (start_i) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign count_out = r_count;
  assign tc_o      = r_tc;
  assign busy_o    = r_busy;

endmodule : reload_down_timer

// File: tb/tb_reload_down_timer.sv
// -----------------------------------------------------------------------------
// tb_reload_down_timer
// Directed scenarios plus randomized traffic, every cycle compared against a
// behavioural timer model kept in this file.
// -----------------------------------------------------------------------------
module tb_reload_down_timer;

  localparam int W  = 4;
  localparam int PS = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_i;
  logic [W-1:0] load;
  logic         start_i;
  logic         stop_i;
  logic         auto_i;
  logic [W-1:0] count_out;
  logic         tc_o;
  logic         busy_o;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: "active" = a count is in progress, "paused" = frozen.
  bit m_active;
  bit m_paused;
  bit m_tc;
  int m_count;
  int m_reload;
  int m_pc;

  always #5 clk = ~clk;

  reload_down_timer #(
    .WIDTH    (W),
    .PRESCALE (PS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load_i),
    .load      (load),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .auto_i    (auto_i),
    .count_out (count_out),
    .tc_o      (tc_o),
    .busy_o    (busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_paused = 1'b0;
    m_tc     = 1'b0;
    m_count  = 0;
    m_reload = 0;
    m_pc     = 0;
  endtask

  // One clock edge of the timer's documented behaviour.
  task automatic model_step(input bit ld, input int lv, input bit st, input bit sp, input bit au);
    int  prev_reload;
    bit  tick;
    prev_reload = m_reload;
    if (ld) m_reload = lv;
    m_tc = 1'b0;
    if (!m_active) begin
      if (st) begin
        m_active = 1'b1;
        m_paused = 1'b0;
        m_count  = m_reload;
        m_pc     = 0;
      end else if (ld) begin
        m_count = lv;
      end
    end else if (m_paused) begin
      if (st) m_paused = 1'b0;
    end else if (sp) begin
      m_paused = 1'b1;
    end else begin
`ifdef RELOAD_TIMER_PRESCALE_EN
      tick = (m_pc == PS - 1);
      m_pc = (m_pc + 1) % PS;
`else
      tick = 1'b1;
`endif
      if (tick) begin
        if (m_count == 0) begin
          m_tc = 1'b1;
          if (au) m_count = prev_reload;
          else    m_active = 1'b0;
        end else begin
          m_count = m_count - 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".count"}, 32'(count_out), 32'(m_count));
    check_eq({tag, ".tc"},    32'(tc_o),      32'(m_tc));
    check_eq({tag, ".busy"},  32'(busy_o),    32'(m_active));
  endtask

  // Drive one cycle of inputs, step the model on the edge, compare after it.
  task automatic cyc(input string tag, input bit ld, input int lv, input bit st, input bit sp, input bit au);
    load_i  = ld;
    load    = W'(lv);
    start_i = st;
    stop_i  = sp;
    auto_i  = au;
    @(posedge clk);
    model_step(ld, lv, st, sp, au);
    #1;
    check_outputs(tag);
    load_i  = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  int tc_seen;

  initial begin
    reset   = 1'b1;
    load_i  = 1'b0;
    load    = '0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    auto_i  = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // One-shot: 3,2,1,0 then tc, then idle at 0.
    cyc("os_load", 1'b1, 3, 1'b0, 1'b0, 1'b0);
    cyc("os_start", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    drain("os_run", 8);
`ifndef RELOAD_TIMER_PRESCALE_EN
    check_eq("os_final_count", 32'(count_out), 32'd0);
    check_eq("os_final_busy",  32'(busy_o),    32'd0);
`endif

    // Auto-reload with reload 2: 3 pulses in 9 cycles.
    cyc("ar_start", 1'b1, 2, 1'b1, 1'b0, 1'b1);
    tc_seen = 0;
    for (int i = 0; i < 9; i++) begin
      cyc("ar_run", 1'b0, 0, 1'b0, 1'b0, 1'b1);
      tc_seen += int'(tc_o);
    end
`ifndef RELOAD_TIMER_PRESCALE_EN
    check_eq("ar_pulses", 32'(tc_seen), 32'd3);
`endif
    for (int i = 0; i < 40; i++) cyc("ar_end", 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Pause at 5 for 4 cycles, resume, then start+stop together in RUN.
    cyc("ps_start", 1'b1, 9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc("ps_run", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc("ps_stop", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("ps_hold", 1'b0, 0, 1'b0, 1'b1, 1'b0);
`ifndef RELOAD_TIMER_PRESCALE_EN
    check_eq("ps_frozen", 32'(count_out), 32'd5);
`endif
    cyc("ps_resume", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    cyc("ps_both", 1'b0, 0, 1'b1, 1'b1, 1'b0);
    cyc("ps_hold2", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc("ps_resume2", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    drain("ps_end", 60);

    // Reload 0 in auto mode: tc every cycle; load F mid-run applies after next tc.
    cyc("er_start", 1'b1, 0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc("er_zero", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    cyc("er_loadF", 1'b1, 15, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc("er_run", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    drain("er_end", 80);

    // Reset mid-run at count 7: outputs clear immediately, no tc afterwards.
    cyc("rs_start", 1'b1, 7, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_outputs("rs_async");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("rs_release");
    for (int i = 0; i < 10; i++) cyc("rs_after", 1'b0, 0, 1'b0, 1'b0, 1'b0);

`ifdef RELOAD_TIMER_PRESCALE_EN
    // Prescaled one-shot with reload 1: tc visible 8 cycles after start.
    cyc("pr_start", 1'b1, 1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc("pr_run", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc("pr_tc", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("pr_tc_at_8", 32'(tc_o), 32'd1);
    drain("pr_end", 4);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc("rand",
          ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 15)),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_reload_down_timer
